// File: rtl/floor_seq_ctrl.sv
`timescale 1ns/1ps
// floor_seq_ctrl: four-floor lift sequencer with latched calls, timed travel and door dwell.
// Optional macro FLOOR_SEQ_ESTOP_EN adds the estop input and STOP state.
module floor_seq_ctrl #(
   parameter int TICKS_PER_FLOOR = 50000000,
   parameter int DOOR_TICKS      = 100000000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       door_hold,
`ifdef FLOOR_SEQ_ESTOP_EN
   input  logic       estop,
`endif
   output logic [3:0] data,
   output logic [1:0] floor,
   output logic       moving,
   output logic       door_open,
   output logic [3:0] pending
);

   localparam int MAX_TICKS = (TICKS_PER_FLOOR > DOOR_TICKS) ? TICKS_PER_FLOOR : DOOR_TICKS;
   localparam int TW        = $clog2(MAX_TICKS);
   localparam logic [TW-1:0] TRAVEL_LAST = TW'(TICKS_PER_FLOOR - 1);
   localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_TICKS - 1);
   localparam logic [TW-1:0] T_ZERO      = TW'(0);
   localparam logic [TW-1:0] T_ONE       = TW'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MOVE_UP   = 3'd1,
      ST_MOVE_DOWN = 3'd2,
      ST_DOOR      = 3'd3,
      ST_STOP      = 3'd4
   } state_t;

   function automatic logic [3:0] above_mask(input logic [1:0] f);
      case (f)
         2'd0:    above_mask = 4'b1110;
         2'd1:    above_mask = 4'b1100;
         2'd2:    above_mask = 4'b1000;
         default: above_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] below_mask(input logic [1:0] f);
      case (f)
         2'd0:    below_mask = 4'b0000;
         2'd1:    below_mask = 4'b0001;
         2'd2:    below_mask = 4'b0011;
         default: below_mask = 4'b0111;
      endcase
   endfunction

   logic [3:0]    sync_r [SYNC_STAGES];
   logic [3:0]    prev_r;
   logic [3:0]    rise_s;
   state_t        state_r, state_n_s;
   logic [1:0]    floor_r, floor_n_s, nf_s;
   logic          dir_r, dir_n_s;
   logic [3:0]    pending_r, pending_n_s, set_s, clr_s, here_s;
   logic [TW-1:0] travel_r, travel_n_s, door_r, door_n_s;
   logic [3:0]    data_r, data_n_s;
   logic          moving_r, moving_n_s, door_open_r, door_open_n_s;
   logic          calls_up_s, calls_dn_s;

   assign rise_s     = sync_r[SYNC_STAGES-1] & ~prev_r;
   assign here_s     = 4'b0001 << floor_r;
   assign calls_up_s = |(pending_r & above_mask(floor_r));
   assign calls_dn_s = |(pending_r & below_mask(floor_r));

   // Button synchronizer chain and previous-value register for rise detection
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 4'h0;
         prev_r <= 4'h0;
      end else begin
         sync_r[0] <= req;
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   // Next-state, timer, floor and call-latch logic
   always_comb begin
      state_n_s  = state_r;
      floor_n_s  = floor_r;
      dir_n_s    = dir_r;
      travel_n_s = travel_r;
      door_n_s   = door_r;
      nf_s       = floor_r;
      set_s      = rise_s;
      clr_s      = 4'h0;
`ifdef FLOOR_SEQ_ESTOP_EN
      if (estop) begin
         state_n_s  = ST_STOP;
         travel_n_s = T_ZERO;
         door_n_s   = T_ZERO;
         set_s      = 4'h0;
         clr_s      = 4'hf;
      end else begin
`endif
      case (state_r)
         ST_IDLE: begin
            travel_n_s = T_ZERO;
            if ((pending_r & here_s) != 4'h0) begin
               state_n_s = ST_DOOR;
               clr_s     = here_s;
               door_n_s  = DOOR_LOAD;
            end else if (dir_r && calls_up_s) begin
               state_n_s = ST_MOVE_UP;
            end else if (!dir_r && calls_dn_s) begin
               state_n_s = ST_MOVE_DOWN;
            end else if (calls_up_s) begin
               dir_n_s   = 1'b1;
               state_n_s = ST_MOVE_UP;
            end else if (calls_dn_s) begin
               dir_n_s   = 1'b0;
               state_n_s = ST_MOVE_DOWN;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_MOVE_UP: begin
            if (travel_r == TRAVEL_LAST) begin
               travel_n_s = T_ZERO;
               if (floor_r != 2'd3) nf_s = floor_r + 2'd1;
               else                 nf_s = floor_r;
               floor_n_s = nf_s;
               // Arrival decision uses the calls latched before this cycle
               if (pending_r[nf_s]) begin
                  state_n_s = ST_DOOR;
                  clr_s     = 4'b0001 << nf_s;
                  door_n_s  = DOOR_LOAD;
               end else if ((pending_r & above_mask(nf_s)) != 4'h0) begin
                  state_n_s = ST_MOVE_UP;
               end else begin
                  state_n_s = ST_IDLE;
               end
            end else begin
               travel_n_s = travel_r + T_ONE;
            end
         end
         ST_MOVE_DOWN: begin
            if (travel_r == TRAVEL_LAST) begin
               travel_n_s = T_ZERO;
               if (floor_r != 2'd0) nf_s = floor_r - 2'd1;
               else                 nf_s = floor_r;
               floor_n_s = nf_s;
               if (pending_r[nf_s]) begin
                  state_n_s = ST_DOOR;
                  clr_s     = 4'b0001 << nf_s;
                  door_n_s  = DOOR_LOAD;
               end else if ((pending_r & below_mask(nf_s)) != 4'h0) begin
                  state_n_s = ST_MOVE_DOWN;
               end else begin
                  state_n_s = ST_IDLE;
               end
            end else begin
               travel_n_s = travel_r + T_ONE;
            end
         end
         ST_DOOR: begin
            // A press for the open floor extends the dwell instead of latching
            set_s = rise_s & ~here_s;
            if (door_hold || ((rise_s & here_s) != 4'h0)) begin
               door_n_s = DOOR_LOAD;
            end else if (door_r == T_ZERO) begin
               state_n_s = ST_IDLE;
            end else begin
               door_n_s = door_r - T_ONE;
            end
         end
         ST_STOP: begin
            state_n_s  = ST_IDLE;
            travel_n_s = T_ZERO;
            door_n_s   = T_ZERO;
         end
         default: begin
            state_n_s  = ST_IDLE;
            travel_n_s = T_ZERO;
            door_n_s   = T_ZERO;
         end
      endcase
`ifdef FLOOR_SEQ_ESTOP_EN
      end
`endif
      pending_n_s = (pending_r | set_s) & ~clr_s;
   end

   // Output decode: status flags follow the next state, display follows the current one
   always_comb begin
      moving_n_s    = 1'b0;
      door_open_n_s = 1'b0;
      data_n_s      = {2'b00, floor_r};
      if (state_n_s == ST_MOVE_UP || state_n_s == ST_MOVE_DOWN) moving_n_s = 1'b1;
      else                                                       moving_n_s = 1'b0;
      if (state_n_s == ST_DOOR) door_open_n_s = 1'b1;
      else                      door_open_n_s = 1'b0;
      if (state_r == ST_DOOR || state_r == ST_STOP) data_n_s = 4'd6;
      else                                          data_n_s = {2'b00, floor_r};
   end

   // State, timers, call latch and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         floor_r     <= 2'd0;
         dir_r       <= 1'b1;
         pending_r   <= 4'h0;
         travel_r    <= T_ZERO;
         door_r      <= T_ZERO;
         data_r      <= 4'd0;
         moving_r    <= 1'b0;
         door_open_r <= 1'b0;
      end else begin
         state_r     <= state_n_s;
         floor_r     <= floor_n_s;
         dir_r       <= dir_n_s;
         pending_r   <= pending_n_s;
         travel_r    <= travel_n_s;
         door_r      <= door_n_s;
         data_r      <= data_n_s;
         moving_r    <= moving_n_s;
         door_open_r <= door_open_n_s;
      end
   end

   assign data      = data_r;
   assign floor     = floor_r;
   assign moving    = moving_r;
   assign door_open = door_open_r;
   assign pending   = pending_r;

endmodule

// File: tb/tb_floor_seq_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for floor_seq_ctrl: a service-order model predicts door events,
// an independent monitor checks them along with display, step timing and dwell.
module tb_floor_seq_ctrl;
   localparam int TPF = 4;
   localparam int DT  = 6;
   localparam int SS  = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = 4'h0;
   logic       door_hold = 1'b0;
`ifdef FLOOR_SEQ_ESTOP_EN
   logic       estop = 1'b0;
`endif
   logic [3:0] data;
   logic [1:0] floor;
   logic       moving;
   logic       door_open;
   logic [3:0] pending;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int fl;
      int dur;
   } ev_t;
   ev_t sb_q[$];
   bit  mon_en = 1'b0;
   int  model_floor = 0;
   bit  model_up = 1'b1;

   floor_seq_ctrl #(
      .TICKS_PER_FLOOR(TPF),
      .DOOR_TICKS(DT),
      .SYNC_STAGES(SS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .door_hold(door_hold),
`ifdef FLOOR_SEQ_ESTOP_EN
      .estop(estop),
`endif
      .data(data),
      .floor(floor),
      .moving(moving),
      .door_open(door_open),
      .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] m);
      req = m;
      tick();
      tick();
      req = 4'h0;
   endtask

   // Service order: current floor first, then sweep in the travel direction, then reverse
   task automatic predict(input logic [3:0] m);
      int ups[$];
      int dns[$];
      if (m[model_floor]) sb_q.push_back('{model_floor, DT});
      for (int i = model_floor + 1; i < 4; i++) if (m[i]) ups.push_back(i);
      for (int i = model_floor - 1; i >= 0; i--) if (m[i]) dns.push_back(i);
      if (model_up) begin
         foreach (ups[i]) sb_q.push_back('{ups[i], DT});
         foreach (dns[i]) sb_q.push_back('{dns[i], DT});
         if (dns.size() > 0) begin
            model_up = 1'b0;
            model_floor = dns[$];
         end else if (ups.size() > 0) begin
            model_floor = ups[$];
         end
      end else begin
         foreach (dns[i]) sb_q.push_back('{dns[i], DT});
         foreach (ups[i]) sb_q.push_back('{ups[i], DT});
         if (ups.size() > 0) begin
            model_up = 1'b1;
            model_floor = ups[$];
         end else if (dns.size() > 0) begin
            model_floor = dns[$];
         end
      end
   endtask

   task automatic wait_idle();
      int stable = 0;
      bit ok = 1'b0;
      repeat (5) tick();
      for (int k = 0; k < 800; k++) begin
         if (pending == 4'h0 && !moving && !door_open) stable++;
         else stable = 0;
         if (stable >= 3) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("idle_wait", int'(ok), 1);
   endtask

   task automatic wait_door();
      bit ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (door_open) begin
            ok = 1'b1;
            break;
         end
      end
      chk("door_wait", int'(ok), 1);
   endtask

   task automatic wait_floor(input int f);
      bit ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (int'(floor) == f) begin
            ok = 1'b1;
            break;
         end
      end
      chk("floor_wait", int'(ok), 1);
   endtask

   task automatic call(input logic [3:0] m);
      predict(m);
      press(m);
      wait_idle();
      chk("rest_floor", int'(floor), model_floor);
   endtask

   // Monitor state
   bit   have_prev = 1'b0;
   int   p_floor, p_door, p_moving;
   int   seg_cnt = 0;
   int   door_cnt = 0;
   int   cur_dur = DT;
   ev_t  mon_e;

   initial begin
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            have_prev = 1'b0;
            seg_cnt   = 0;
            door_cnt  = 0;
         end else begin
            if (have_prev) begin
               chk("data_code", int'(data), (p_door != 0) ? 6 : p_floor);
               if (int'(floor) != p_floor) begin
                  chk("floor_step", (int'(floor) > p_floor) ? int'(floor) - p_floor : p_floor - int'(floor), 1);
                  chk("floor_interval", seg_cnt, TPF);
                  seg_cnt = moving ? 1 : 0;
               end else if (moving && p_moving == 0) begin
                  seg_cnt = 1;
               end else if (moving) begin
                  seg_cnt++;
               end else begin
                  seg_cnt = 0;
               end
               if (door_open && p_door == 0) begin
                  if (sb_q.size() == 0) begin
                     chk("sb_underflow", 1, 0);
                     cur_dur = DT;
                  end else begin
                     mon_e = sb_q.pop_front();
                     chk("door_floor", int'(floor), mon_e.fl);
                     cur_dur = mon_e.dur;
                  end
                  chk("door_pending_clr", int'(pending[floor]), 0);
                  door_cnt = 1;
               end else if (door_open) begin
                  door_cnt++;
               end else if (p_door != 0) begin
                  chk("door_dwell", door_cnt, cur_dur);
               end
            end
            have_prev = 1'b1;
            p_floor   = int'(floor);
            p_door    = int'(door_open);
            p_moving  = int'(moving);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      mon_en = 1'b1;

      // Quiet after reset
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("rst_data", int'(data), 0);
         chk("rst_floor", int'(floor), 0);
         chk("rst_pending", int'(pending), 0);
         chk("rst_moving", int'(moving), 0);
         chk("rst_door", int'(door_open), 0);
      end

      // Call at the current floor: latency and dwell
      sb_q.push_back('{0, DT});
      req = 4'b0001;
      tick();
      tick();
      req = 4'h0;
      chk("pend_early", int'(pending), 0);
      tick();
      chk("pend_latency", int'(pending), 1);
      chk("door_not_yet", int'(door_open), 0);
      tick();
      chk("door_enter", int'(door_open), 1);
      chk("data_lag", int'(data), 0);
      for (int i = 0; i < DT; i++) begin
         tick();
         chk("data_h", int'(data), 6);
      end
      chk("door_closed", int'(door_open), 0);
      tick();
      chk("data_back", int'(data), 0);
      wait_idle();

      call(4'b1000);
      call(4'b0011);

      // Door hold for 10 cycles extends the dwell to 10 + DT
      sb_q.push_back('{model_floor, 10 + DT});
      req = 4'b0001 << model_floor;
      tick();
      tick();
      req = 4'h0;
      wait_door();
      door_hold = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      door_hold = 1'b0;
      wait_idle();

      // Re-press during DOOR reloads the timer; held button latches nothing
      sb_q.push_back('{model_floor, 9});
      press(4'b0001 << model_floor);
      wait_door();
      req = 4'b0001 << model_floor;
      repeat (20) tick();
      chk("held_no_relatch", int'(pending), 0);
      chk("held_door_closed", int'(door_open), 0);
      req = 4'h0;
      wait_idle();

      for (int n = 0; n < 30; n++) begin
         call(4'($urandom_range(1, 15)));
         repeat ($urandom_range(0, 5)) tick();
      end

`ifdef FLOOR_SEQ_ESTOP_EN
      call(4'b0001);
      press(4'b1000);
      wait_floor(1);
      mon_en = 1'b0;
      sb_q.delete();
      estop = 1'b1;
      tick();
      chk("estop_moving", int'(moving), 0);
      chk("estop_door", int'(door_open), 0);
      chk("estop_floor", int'(floor), 1);
      chk("estop_pending", int'(pending), 0);
      tick();
      chk("estop_data", int'(data), 6);
      press(4'b0100);
      repeat (3) tick();
      chk("estop_block", int'(pending), 0);
      estop = 1'b0;
      tick();
      tick();
      chk("estop_rel_data", int'(data), 1);
      chk("estop_rel_moving", int'(moving), 0);
      model_floor = 1;
      model_up = 1'b1;
      mon_en = 1'b1;
      call(4'b1000);
`endif

      // Reset while travelling between floors 1 and 2
      call(4'b0001);
      press(4'b1000);
      wait_floor(1);
      tick();
      tick();
      chk("mid_move", int'(moving), 1);
      mon_en = 1'b0;
      sb_q.delete();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_floor", int'(floor), 0);
      chk("mr_pending", int'(pending), 0);
      chk("mr_data", int'(data), 0);
      chk("mr_moving", int'(moving), 0);
      chk("mr_door", int'(door_open), 0);
      model_floor = 0;
      model_up = 1'b1;
      mon_en = 1'b1;
      call(4'b0100);

      chk("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
